// File: rtl/shift_sequencer_if.sv
// ---------------------------------------------------------------------------
// shift_sequencer_if
//   Command/response bundle between the ALU control FSM (master) and the
//   multi-cycle shift sequencer (slave).
//
//   Command (master -> slave):
//     start       command strobe, accepted only while busy==0
//     operand     value to shift            [WIDTH-1:0]
//     amount      number of 1-bit steps     [AMT_W-1:0]
//     direction   0 = left, 1 = right
//     arithmetic  sign-fill on right shift
//     rotate      rotate mode (present only with SHIFT_ROTATE_EN)
//   Response (slave -> master):
//     busy        command in progress
//     done        one-cycle pulse, result/carry valid
//     result      shifted value             [WIDTH-1:0]
//     carry       last bit shifted out
//
//   Optional feature macro: SHIFT_ROTATE_EN
// ---------------------------------------------------------------------------
interface shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
);
    logic             start;
    logic [WIDTH-1:0] operand;
    logic [AMT_W-1:0] amount;
    logic             direction;
    logic             arithmetic;
`ifdef SHIFT_ROTATE_EN
    logic             rotate;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;

    modport master (
        output start, operand, amount, direction, arithmetic,
`ifdef SHIFT_ROTATE_EN
        output rotate,
`endif
        input  busy, done, result, carry
    );

    modport slave (
        input  start, operand, amount, direction, arithmetic,
`ifdef SHIFT_ROTATE_EN
        input  rotate,
`endif
        output busy, done, result, carry
    );
endinterface

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//   Multi-cycle shift controller: accepts one shift command through a
//   start/busy/done handshake and applies one single-bit shift step per
//   clock, so an N-bit shift reuses a 1-bit shift stage over N cycles.
//
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset (synchronously released)
//     bus      shift_sequencer_if.slave (start/operand/amount/direction/
//              arithmetic[/rotate] in; busy/done/result/carry out)
//
//   Optional feature macro: SHIFT_ROTATE_EN
//     Defined: rotate input exists; rotate=1 selects rotate mode and the
//     arithmetic flag is ignored. Undefined: shift modes only.
// ---------------------------------------------------------------------------
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    shift_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] work, work_next;
    logic             carry_q, carry_next;
    logic [AMT_W-1:0] count, count_next;
    logic             dir_q, dir_next;
    logic             arith_q, arith_next;
`ifdef SHIFT_ROTATE_EN
    logic             rot_q, rot_next;
`endif

    logic [WIDTH-1:0] step_res;
    logic             step_car;
    logic             fill_left;
    logic             fill_right;

    // Single-bit shift stage. Rotation is just a different fill bit; the
    // carry is always the bit leaving the word.
    always_comb begin
        fill_left  = 1'b0;
        fill_right = arith_q & work[WIDTH-1];
`ifdef SHIFT_ROTATE_EN
        if (rot_q) begin
            fill_left  = work[WIDTH-1];
            fill_right = work[0];
        end
`endif
        if (dir_q) begin
            step_res = {fill_right, work[WIDTH-1:1]};
            step_car = work[0];
        end else begin
            step_res = {work[WIDTH-2:0], fill_left};
            step_car = work[WIDTH-1];
        end
    end

    always_comb begin
        state_next = state;
        work_next  = work;
        carry_next = carry_q;
        count_next = count;
        dir_next   = dir_q;
        arith_next = arith_q;
`ifdef SHIFT_ROTATE_EN
        rot_next   = rot_q;
`endif
        case (state)
            IDLE, DONE: begin
                // DONE accepts a new command exactly like IDLE, giving
                // back-to-back operation without an idle cycle.
                if (bus.start) begin
                    state_next = SHIFT;
                    work_next  = bus.operand;
                    carry_next = 1'b0;
                    count_next = bus.amount;
                    dir_next   = bus.direction;
                    arith_next = bus.arithmetic;
`ifdef SHIFT_ROTATE_EN
                    rot_next   = bus.rotate;
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                if (count == '0) begin
                    state_next = DONE;
                end else begin
                    work_next  = step_res;
                    carry_next = step_car;
                    count_next = count - AMT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            work    <= '0;
            carry_q <= 1'b0;
            count   <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
`ifdef SHIFT_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            work    <= work_next;
            carry_q <= carry_next;
            count   <= count_next;
            dir_q   <= dir_next;
            arith_q <= arith_next;
`ifdef SHIFT_ROTATE_EN
            rot_q   <= rot_next;
`endif
        end
    end

    assign bus.busy   = (state == SHIFT);
    assign bus.done   = (state == DONE);
    assign bus.result = work;
    assign bus.carry  = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
//   Self-checking bench for shift_sequencer (WIDTH=8). Expected results come
//   from a whole-word arithmetic model of an N-bit shift/rotate.
//   Optional feature macro: SHIFT_ROTATE_EN
// ---------------------------------------------------------------------------
module tb_shift_sequencer;

    localparam int W  = 8;
    localparam int AW = 3;

    logic clk;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    shift_sequencer_if #(.WIDTH(W), .AMT_W(AW)) bus ();

    shift_sequencer #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Returns {carry, result} for a full N-bit operation.
    function automatic logic [W:0] model(input logic [W-1:0] op, input int amt,
                                         input bit dir, input bit ar, input bit rt);
        logic [W-1:0] r;
        logic         c;
        if (amt == 0) return {1'b0, op};
        if (!dir) begin
            c = op[W-amt];
            r = rt ? W'((op << amt) | (op >> (W - amt))) : W'(op << amt);
        end else begin
            c = op[amt-1];
            if (rt)      r = W'((op >> amt) | (op << (W - amt)));
            else if (ar) r = W'($signed(op) >>> amt);
            else         r = op >> amt;
        end
        return {c, r};
    endfunction

    task automatic issue(input logic [W-1:0] op, input int amt, input bit dir,
                         input bit ar, input bit rt);
        bus.operand    = op;
        bus.amount     = AW'(amt);
        bus.direction  = dir;
        bus.arithmetic = ar;
`ifdef SHIFT_ROTATE_EN
        bus.rotate     = rt;
`else
        if (rt) $display("rotate requested without SHIFT_ROTATE_EN");
`endif
        bus.start      = 1'b1;
    endtask

    // Call at the negedge of the accept cycle; returns at the negedge where
    // busy has dropped (the DONE cycle) with start deasserted.
    task automatic finish_cmd(input logic [W-1:0] op, input int amt, input bit dir,
                              input bit ar, input bit rt, input bit noise);
        logic [W:0] exp;
        int cycles;
        exp = model(op, amt, dir, ar, rt);
        cycles = 0;
        @(negedge clk);
        check("load_result", bus.result, op);
        check("load_carry", bus.carry, 1'b0);
        while (bus.busy && cycles < 64) begin
            cycles++;
            if (noise) begin
                bus.start     = 1'($urandom_range(0, 1));
                bus.operand   = W'($urandom);
                bus.amount    = AW'($urandom);
                bus.direction = 1'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("busy_cycles", cycles, amt + 1);
        check("done", bus.done, 1'b1);
        check("result", bus.result, exp[W-1:0]);
        check("carry", bus.carry, exp[W]);
    endtask

    task automatic idle_hold(input logic [W-1:0] r, input logic c);
        @(negedge clk);
        check("idle_done", bus.done, 1'b0);
        check("idle_busy", bus.busy, 1'b0);
        check("held_result", bus.result, r);
        check("held_carry", bus.carry, c);
    endtask

    task automatic run(input logic [W-1:0] op, input int amt, input bit dir,
                       input bit ar, input bit rt, input bit noise);
        logic [W:0] exp;
        exp = model(op, amt, dir, ar, rt);
        issue(op, amt, dir, ar, rt);
        finish_cmd(op, amt, dir, ar, rt, noise);
        idle_hold(exp[W-1:0], exp[W]);
    endtask

    initial begin
        bit seen_done;
        bus.start = 1'b0; bus.operand = '0; bus.amount = '0;
        bus.direction = 1'b0; bus.arithmetic = 1'b0;
`ifdef SHIFT_ROTATE_EN
        bus.rotate = 1'b0;
`endif
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_result", bus.result, '0);
        check("rst_carry", bus.carry, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run(8'hB5, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        check("b5_direct", bus.result, 8'hA8);
        run(8'h96, 2, 1'b1, 1'b1, 1'b0, 1'b0);
        check("96_arith", bus.result, 8'hE5);
        run(8'h96, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        check("96_logic", bus.result, 8'h25);
        run(8'h3C, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        run(8'h5A, 7, 1'b1, 1'b0, 1'b0, 1'b1);
        run(8'h81, 7, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SHIFT_ROTATE_EN
        run(8'h81, 1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("rot_direct", bus.result, 8'hC0);
`endif

        // Back-to-back: start held in the DONE cycle
        issue(8'hF0, 2, 1'b0, 1'b0, 1'b0);
        finish_cmd(8'hF0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(8'h0F, 3, 1'b1, 1'b0, 1'b0);
        finish_cmd(8'h0F, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_hold(8'h01, 1'b1);

        // Reset asserted mid-command
        issue(8'hFF, 7, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_result", bus.result, '0);
        check("abort_carry", bus.carry, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        seen_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen_done = 1'b1;
        end
        check("abort_no_done", seen_done, 1'b0);

        // Randomized commands, some chained back-to-back
        begin
            logic [W-1:0] op;
            int amt;
            bit dir, ar, rt, nz, chain;
            logic [W:0] exp;
            chain = 1'b0;
            for (int i = 0; i < 60; i++) begin
                op  = W'($urandom);
                amt = $urandom_range(0, W - 1);
                dir = 1'($urandom);
                ar  = 1'($urandom);
`ifdef SHIFT_ROTATE_EN
                rt  = 1'($urandom);
`else
                rt  = 1'b0;
`endif
                nz  = 1'($urandom);
                exp = model(op, amt, dir, ar, rt);
                issue(op, amt, dir, ar, rt);
                finish_cmd(op, amt, dir, ar, rt, nz);
                chain = ($urandom_range(0, 2) == 0);
                if (!chain) idle_hold(exp[W-1:0], exp[W]);
            end
            if (chain) idle_hold(exp[W-1:0], exp[W]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

endmodule
